// File: rtl/peregrine_pif_mem_slave.sv
// peregrine_pif_mem_slave
//   Responder end of the 32-bit Peregrine PIF. Requests are answered from an
//   internal word-addressed memory of 2^DEPTH_LOG2 words mapped at BASE_ADDR.
//   Supports single/block read/write, with RESP_DELAY idle cycles between the
//   last request beat and the first response beat.
//
// Ports
//   CLK, Reset                  clock, synchronous active-high reset
//   POReqValid / PIReqRdy       request beat handshake
//   POReqCntl                   [7:4] opcode, [2:1] block size, [0] last beat
//   POReqAdrs/Data/DataBE       byte address, write data, byte enables
//   POReqId/Priority            transaction tags, echoed on the response
//   PIRespValid / PORespRdy     response beat handshake
//   PIRespCntl                  [7:4] status (0 ok, 1 error), [0] last beat
//   PIRespData                  read data (0 for writes and errors)
//   PIRespId/Priority           echoed request tags
module peregrine_pif_mem_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h6000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          RESP_DELAY = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        POReqValid,
  output logic        PIReqRdy,
  input  logic [7:0]  POReqCntl,
  input  logic [31:0] POReqAdrs,
  input  logic [31:0] POReqData,
  input  logic [3:0]  POReqDataBE,
  input  logic [5:0]  POReqId,
  input  logic [1:0]  POReqPriority,
  output logic        PIRespValid,
  input  logic        PORespRdy,
  output logic [7:0]  PIRespCntl,
  output logic [31:0] PIRespData,
  output logic [5:0]  PIRespId,
  output logic [1:0]  PIRespPriority
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DW    = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

  localparam logic [3:0] OP_RD  = 4'h0;
  localparam logic [3:0] OP_WR  = 4'h8;
  localparam logic [3:0] OP_BRD = 4'h1;
  localparam logic [3:0] OP_BWR = 4'h9;

  typedef enum logic [1:0] {IDLE, WCOLLECT, DELAY, RESP} state_e;
  // With no delay configured the DELAY state is skipped entirely.
  localparam state_e AFTER_REQ = (RESP_DELAY == 0) ? RESP : DELAY;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] base_q, base_d;   // block base word index
  logic [3:0]            mask_q, mask_d;   // beats-1 of the block (0 for singles)
  logic [3:0]            beat_q, beat_d;
  logic [3:0]            last_q, last_d;   // index of the final response beat
  logic [DW-1:0]         dly_q, dly_d;
  logic                  rd_q, rd_d;
  logic                  err_q, err_d;
  logic [5:0]            id_q, id_d;
  logic [1:0]            prio_q, prio_d;

  logic [31:0] mem [DEPTH];

  // ---------------- request decode ----------------
  logic [3:0]            opc;
  logic                  is_rd, is_wr, is_blk, bad_op, in_range, req_acc;
  logic [31:0]           off;
  logic [4:0]            nbeats;
  logic [3:0]            req_mask;
  logic [DEPTH_LOG2-1:0] req_base;
  logic                  unused_bits;

  assign opc      = POReqCntl[7:4];
  assign is_rd    = (opc == OP_RD) || (opc == OP_BRD);
  assign is_wr    = (opc == OP_WR) || (opc == OP_BWR);
  assign is_blk   = (opc == OP_BRD) || (opc == OP_BWR);
  assign bad_op   = !(is_rd || is_wr);
  assign off      = POReqAdrs - BASE_ADDR;
  // Lower bound checked before using the offset so the subtraction cannot wrap.
  assign in_range = (POReqAdrs >= BASE_ADDR) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign nbeats   = 5'd2 << POReqCntl[2:1];
  assign req_mask = is_blk ? 4'(nbeats - 5'd1) : 4'd0;
  assign req_base = off[DEPTH_LOG2+1:2] & ~DEPTH_LOG2'(req_mask);
  assign unused_bits = ^{POReqCntl[3], off[1:0]};

  assign PIReqRdy = !Reset && ((state_q == IDLE) || (state_q == WCOLLECT));
  assign req_acc  = POReqValid && PIReqRdy;

  // ---------------- memory write port ----------------
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (POReqDataBE[b]) mem[mem_waddr][b*8 +: 8] <= POReqData[b*8 +: 8];
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      mask_q  <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      dly_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      dly_q   <= dly_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    mask_d    = mask_q;
    beat_d    = beat_q;
    last_d    = last_q;
    dly_d     = dly_q;
    rd_d      = rd_q;
    err_d     = err_q;
    id_d      = id_q;
    prio_d    = prio_q;
    mem_we    = 1'b0;
    mem_waddr = base_q + DEPTH_LOG2'(beat_q & mask_q);
    unique case (state_q)
      IDLE: begin
        if (req_acc) begin
          id_d    = POReqId;
          prio_d  = POReqPriority;
          base_d  = req_base;
          mask_d  = req_mask;
          rd_d    = is_rd;
          err_d   = bad_op || !in_range;
          // Reads return the whole block even on error; writes answer once.
          last_d  = is_rd ? req_mask : 4'd0;
          beat_d  = 4'd0;
          dly_d   = '0;
          state_d = AFTER_REQ;
          if (is_wr) begin
            mem_we    = in_range;
            mem_waddr = req_base;
            if (is_blk && !POReqCntl[0]) begin
              state_d = WCOLLECT;
              beat_d  = 4'd1;
            end
          end
        end
      end
      WCOLLECT: begin
        if (req_acc) begin
          // Errored block writes still drain their beats but never write.
          mem_we = !err_q;
          beat_d = (beat_q + 4'd1) & mask_q;
          if (POReqCntl[0]) begin
            beat_d  = 4'd0;
            dly_d   = '0;
            state_d = AFTER_REQ;
          end
        end
      end
      DELAY: begin
        if (int'(dly_q) == RESP_DELAY - 1) begin
          dly_d   = '0;
          state_d = RESP;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      RESP: begin
        if (PORespRdy) begin
          if (beat_q == last_q) begin
            beat_d  = 4'd0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- response outputs ----------------
  logic resp_act;
  assign resp_act       = !Reset && (state_q == RESP);
  assign PIRespValid    = resp_act;
  assign PIRespCntl     = resp_act ? {3'b000, err_q, 3'b000, (beat_q == last_q)} : 8'h00;
  assign PIRespData     = (resp_act && rd_q && !err_q) ? mem[base_q + DEPTH_LOG2'(beat_q)] : 32'h0;
  assign PIRespId       = resp_act ? id_q : 6'h0;
  assign PIRespPriority = resp_act ? prio_q : 2'h0;

endmodule

// File: tb/tb_peregrine_pif_mem_slave.sv
module tb_peregrine_pif_mem_slave;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                  rst;
  logic [1:0]            req_valid, req_rdy, resp_valid, resp_rdy;
  logic [7:0]            req_cntl;
  logic [31:0]           req_adrs, req_data;
  logic [3:0]            req_be;
  logic [5:0]            req_id;
  logic [1:0]            req_prio;
  logic [1:0][7:0]       resp_cntl;
  logic [1:0][31:0]      resp_data;
  logic [1:0][5:0]       resp_id;
  logic [1:0][1:0]       resp_prio;

  // Instance 0: default build (RESP_DELAY=2). Instance 1: RESP_DELAY=0.
  peregrine_pif_mem_slave u_dut (
    .CLK(CLK), .Reset(rst),
    .POReqValid(req_valid[0]), .PIReqRdy(req_rdy[0]),
    .POReqCntl(req_cntl), .POReqAdrs(req_adrs), .POReqData(req_data),
    .POReqDataBE(req_be), .POReqId(req_id), .POReqPriority(req_prio),
    .PIRespValid(resp_valid[0]), .PORespRdy(resp_rdy[0]),
    .PIRespCntl(resp_cntl[0]), .PIRespData(resp_data[0]),
    .PIRespId(resp_id[0]), .PIRespPriority(resp_prio[0])
  );

  peregrine_pif_mem_slave #(.RESP_DELAY(0)) u_dut0 (
    .CLK(CLK), .Reset(rst),
    .POReqValid(req_valid[1]), .PIReqRdy(req_rdy[1]),
    .POReqCntl(req_cntl), .POReqAdrs(req_adrs), .POReqData(req_data),
    .POReqDataBE(req_be), .POReqId(req_id), .POReqPriority(req_prio),
    .PIRespValid(resp_valid[1]), .PORespRdy(resp_rdy[1]),
    .PIRespCntl(resp_cntl[1]), .PIRespData(resp_data[1]),
    .PIRespId(resp_id[1]), .PIRespPriority(resp_prio[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_beat(input int d, input logic [3:0] op, input logic [1:0] sz,
                           input logic last, input logic [31:0] a, input logic [31:0] dt,
                           input logic [3:0] be, input logic [5:0] id, input logic [1:0] pr);
    logic acc;
    acc       = 1'b0;
    req_cntl  = {op, 1'b0, sz, last};
    req_adrs  = a;
    req_data  = dt;
    req_be    = be;
    req_id    = id;
    req_prio  = pr;
    req_valid[d] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = req_rdy[d];
      @(posedge CLK); #1;
      if (acc) break;
    end
    req_valid[d] = 1'b0;
    if (!acc) begin
      n_assert++;
      n_fail++;
      $display("FAIL req_accept: got no accept expected accept within 50 cycles (dut %0d)", d);
    end
  endtask

  // Called just after the accepting edge; lat counts edges until valid seen.
  task automatic wait_valid(input int d, output int lat);
    lat = 1;
    while (!resp_valid[d] && lat < 50) begin
      @(posedge CLK); #1;
      lat++;
    end
    if (!resp_valid[d]) begin
      n_assert++;
      n_fail++;
      $display("FAIL resp_timeout: got no response expected response within 50 cycles (dut %0d)", d);
    end
  endtask

  task automatic get_resp(input int d, output logic [7:0] c, output logic [31:0] dt,
                          output logic [5:0] id, output logic [1:0] pr, output int lat);
    wait_valid(d, lat);
    c  = resp_cntl[d];
    dt = resp_data[d];
    id = resp_id[d];
    pr = resp_prio[d];
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] adrs;
    logic [31:0] data;
    logic [3:0]  be;
    logic [5:0]  id;
    logic [1:0]  prio;
    logic [7:0]  exp_cntl;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    logic [7:0]  c;
    logic [31:0] dt;
    logic [5:0]  id;
    logic [1:0]  pr;
    int          lat;

    //           op     adrs          data          be    id  pr  cntl   data
    vecs[0]  = '{4'h8, 32'h6000_0010, 32'hDEAD_BEEF, 4'hF, 5,  0, 8'h01, 32'h0};
    vecs[1]  = '{4'h0, 32'h6000_0010, 32'h0,         4'h0, 6,  1, 8'h01, 32'hDEAD_BEEF};
    vecs[2]  = '{4'h8, 32'h6000_0010, 32'h1122_3344, 4'h5, 7,  2, 8'h01, 32'h0};
    vecs[3]  = '{4'h0, 32'h6000_0010, 32'h0,         4'h0, 8,  3, 8'h01, 32'hDE22_BE44};
    vecs[4]  = '{4'h8, 32'h6000_0FFC, 32'hCAFE_F00D, 4'hF, 9,  0, 8'h01, 32'h0};
    vecs[5]  = '{4'h0, 32'h6000_0FFC, 32'h0,         4'h0, 10, 1, 8'h01, 32'hCAFE_F00D};
    vecs[6]  = '{4'h8, 32'h6000_0000, 32'h0BAD_F00D, 4'hF, 11, 2, 8'h01, 32'h0};
    vecs[7]  = '{4'h0, 32'h5FFF_FFFC, 32'h0,         4'h0, 12, 3, 8'h11, 32'h0};
    vecs[8]  = '{4'h8, 32'h6000_1000, 32'hFFFF_FFFF, 4'hF, 13, 0, 8'h11, 32'h0};
    vecs[9]  = '{4'h3, 32'h6000_0010, 32'hFFFF_FFFF, 4'hF, 14, 1, 8'h11, 32'h0};
    vecs[10] = '{4'h0, 32'h6000_0000, 32'h0,         4'h0, 15, 2, 8'h01, 32'h0BAD_F00D};
    vecs[11] = '{4'h0, 32'h6000_0010, 32'h0,         4'h0, 16, 3, 8'h01, 32'hDE22_BE44};

    rst = 1'b1;
    req_valid = 2'b00;
    resp_rdy  = 2'b11;
    req_cntl = '0; req_adrs = '0; req_data = '0; req_be = '0; req_id = '0; req_prio = '0;

    // Reset state: every output low while Reset is high.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_reqrdy",  32'(req_rdy[0]),    32'h0);
    check("rst_rvalid",  32'(resp_valid[0]), 32'h0);
    check("rst_rcntl",   32'(resp_cntl[0]),  32'h0);
    check("rst_rdata",   resp_data[0],       32'h0);
    rst = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_reqrdy",  32'(req_rdy[0]), 32'h1);
    check("post_rst_reqrdy0", 32'(req_rdy[1]), 32'h1);

    // Single read/write, byte merge, range and opcode errors.
    for (int i = 0; i < 12; i++) begin
      send_beat(0, vecs[i].op, 2'd0, 1'b1, vecs[i].adrs, vecs[i].data, vecs[i].be,
                vecs[i].id, vecs[i].prio);
      get_resp(0, c, dt, id, pr, lat);
      check($sformatf("v%0d_lat", i),  32'(lat), 32'd3);
      check($sformatf("v%0d_cntl", i), 32'(c),   32'(vecs[i].exp_cntl));
      check($sformatf("v%0d_data", i), dt,       vecs[i].exp_data);
      check($sformatf("v%0d_id", i),   32'(id),  32'(vecs[i].id));
      check($sformatf("v%0d_prio", i), 32'(pr),  32'(vecs[i].prio));
    end

    // 4-beat block write to 0x20, then block read from 0x28 (aligns to 0x20)
    // with the second response beat stalled for 5 cycles.
    for (int b = 0; b < 4; b++)
      send_beat(0, 4'h9, 2'd1, (b == 3), 32'h6000_0020, 32'(b + 1), 4'hF, 6'd20, 2'd1);
    get_resp(0, c, dt, id, pr, lat);
    check("bw_lat",  32'(lat), 32'd3);
    check("bw_cntl", 32'(c),   32'h01);
    check("bw_data", dt,       32'h0);
    check("bw_id",   32'(id),  32'd20);

    send_beat(0, 4'h1, 2'd1, 1'b1, 32'h6000_0028, 32'h0, 4'h0, 6'd21, 2'd2);
    for (int b = 0; b < 4; b++) begin
      wait_valid(0, lat);
      if (b == 0) check("br_lat", 32'(lat), 32'd3);
      check($sformatf("br%0d_data", b), resp_data[0],        32'(b + 1));
      check($sformatf("br%0d_cntl", b), 32'(resp_cntl[0]),   (b == 3) ? 32'h01 : 32'h00);
      check($sformatf("br%0d_id", b),   32'(resp_id[0]),     32'd21);
      check($sformatf("br%0d_rdy", b),  32'(req_rdy[0]),     32'h0);
      if (b == 1) begin
        resp_rdy[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge CLK); #1;
          check($sformatf("stall%0d_valid", k), 32'(resp_valid[0]), 32'h1);
          check($sformatf("stall%0d_data", k),  resp_data[0],       32'd2);
        end
        resp_rdy[0] = 1'b1;
      end
      @(posedge CLK); #1;
    end
    check("br_done_valid",  32'(resp_valid[0]), 32'h0);
    check("br_done_reqrdy", 32'(req_rdy[0]),    32'h1);

    // Reset during a 16-beat block read after six beats.
    send_beat(0, 4'h1, 2'd3, 1'b1, 32'h6000_0000, 32'h0, 4'h0, 6'd30, 2'd0);
    for (int b = 0; b < 6; b++) get_resp(0, c, dt, id, pr, lat);
    check("pre_rst_valid", 32'(resp_valid[0]), 32'h1);
    rst = 1'b1;
    @(posedge CLK); #1;
    check("midrst_valid",  32'(resp_valid[0]), 32'h0);
    check("midrst_reqrdy", 32'(req_rdy[0]),    32'h0);
    rst = 1'b0;
    @(posedge CLK); #1;
    check("rel_valid",  32'(resp_valid[0]), 32'h0);
    check("rel_reqrdy", 32'(req_rdy[0]),    32'h1);
    send_beat(0, 4'h0, 2'd0, 1'b1, 32'h6000_0010, 32'h0, 4'h0, 6'd31, 2'd1);
    get_resp(0, c, dt, id, pr, lat);
    check("after_rst_lat",  32'(lat), 32'd3);
    check("after_rst_cntl", 32'(c),   32'h01);
    check("after_rst_data", dt,       32'hDE22_BE44);
    check("after_rst_id",   32'(id),  32'd31);

    // Zero-delay build: response the cycle after accept, and a request
    // held valid is not accepted until the response has completed.
    send_beat(1, 4'h8, 2'd0, 1'b1, 32'h6000_0040, 32'h1234_5678, 4'hF, 6'd40, 2'd0);
    get_resp(1, c, dt, id, pr, lat);
    check("z_wr_lat",  32'(lat), 32'd1);
    check("z_wr_cntl", 32'(c),   32'h01);
    send_beat(1, 4'h0, 2'd0, 1'b1, 32'h6000_0040, 32'h0, 4'h0, 6'd41, 2'd3);
    check("z_rd_valid", 32'(resp_valid[1]), 32'h1);
    check("z_rd_data",  resp_data[1],       32'h1234_5678);
    check("z_rd_id",    32'(resp_id[1]),    32'd41);
    check("z_rd_prio",  32'(resp_prio[1]),  32'd3);
    // Next request presented while the response is still pending.
    req_cntl = {4'h0, 1'b0, 2'd0, 1'b1};
    req_adrs = 32'h6000_0040;
    req_id   = 6'd42;
    req_valid[1] = 1'b1;
    check("z_b2b_rdy_busy", 32'(req_rdy[1]), 32'h0);
    @(posedge CLK); #1;
    check("z_b2b_valid_gap", 32'(resp_valid[1]), 32'h0);
    check("z_b2b_rdy_back",  32'(req_rdy[1]),    32'h1);
    @(posedge CLK); #1;
    req_valid[1] = 1'b0;
    check("z_b2b_valid", 32'(resp_valid[1]), 32'h1);
    check("z_b2b_data",  resp_data[1],       32'h1234_5678);
    check("z_b2b_id",    32'(resp_id[1]),    32'd42);
    @(posedge CLK); #1;
    check("z_b2b_done", 32'(resp_valid[1]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/peregrine_pif_mem_slave.md
Name: peregrine_pif_mem_slave

Overview:
- PIF slave (responder) end of the 32-bit Peregrine PIF.
- Accepts requests from a master or a pass-through bridge and answers them from an internal word-addressed memory.
- Supports single read/write and block read/write, with a configurable response delay.
- Used as the cosim/bench target behind the master-side PIF path.

Parameters:
- BASE_ADDR, 32'h6000_0000, byte address of word 0; must be aligned to 4*DEPTH.
- DEPTH_LOG2, 10, memory depth is 2^DEPTH_LOG2 32-bit words.
- RESP_DELAY, 2, idle cycles between request completion and first response beat; 0 is legal.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- POReqValid  in  1  request beat valid.
- PIReqRdy  out  1  slave can accept a request beat.
- POReqCntl  in  8  [7:4] opcode, [2:1] block size, [0] last beat.
- POReqAdrs  in  32  byte address.
- POReqData  in  32  write data.
- POReqDataBE  in  4  write byte enables.
- POReqId  in  6  transaction id.
- POReqPriority  in  2  priority.
- PIRespValid  out  1  response beat valid.
- PORespRdy  in  1  master accepts response beat.
- PIRespCntl  out  8  [7:4] status (0 OK, 1 address error), [0] last beat, other bits 0.
- PIRespData  out  32  read data (0 for writes and errors).
- PIRespId  out  6  echoed POReqId.
- PIRespPriority  out  2  echoed POReqPriority.

Behaviour:
Handshakes and encodings:
- A request beat transfers when POReqValid & PIReqRdy; a response beat transfers when PIRespValid & PORespRdy.
- Opcodes: 4'h0 single read, 4'h8 single write, 4'h1 block read, 4'h9 block write; any other opcode is treated as an error.
- Block size field: 0/1/2/3 = 2/4/8/16 beats.

Reset and reset values:
- Reset forces state IDLE and clears the beat counter and delay counter.
- All outputs are 0 while Reset is high, including PIReqRdy.
- Memory contents are not reset.
- Reset mid-transaction aborts it: no further response beats are issued and partial writes stay committed.

States:
- IDLE: PIReqRdy=1. On accept, latch Id, Priority, Adrs, opcode and size.
  - Single write: write memory with DataBE byte merge in the accept cycle, then go to DELAY.
  - Block write: write beat 0, then go to WCOLLECT, or to DELAY if POReqCntl[0]=1.
  - Reads and errors: go to DELAY.
- WCOLLECT: PIReqRdy=1. Each accepted beat writes word (block base + beat count), with the beat count wrapping within the block size. Go to DELAY on the beat with POReqCntl[0]=1.
- DELAY: PIReqRdy=0. Count RESP_DELAY cycles, then go to RESP. With RESP_DELAY=0 the FSM passes straight through and the first response is valid the cycle after the last request beat.
- RESP: PIReqRdy=0; PIRespValid=1 with Id and Priority echoed. Outputs are held stable until PORespRdy.
  - Reads: beat i returns mem[word(block base)+i].
  - Writes: exactly one beat with data 0.
  - Last beat has PIRespCntl[0]=1; after it is accepted, go to IDLE.
  - PIReqRdy returns to 1 in the cycle after the last response beat is accepted.

Address rules:
- Word index = (Adrs - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits.
- Block base = request address with the low log2(beats*4) bits cleared.
- Out of range means Adrs < BASE_ADDR or Adrs >= BASE_ADDR + 4*2^DEPTH_LOG2.
- Out-of-range or bad-opcode requests never write memory.
- Read errors return the full beat count with status 1 and data 0; write and bad-opcode errors return one beat with status 1.

Other rules:
- Only one outstanding transaction.
- Request beats arriving while PIReqRdy=0 are ignored.
- PORespRdy low stalls indefinitely with no timeout.

Test Plan:
1. Reset held 3 cycles, then single write to 0x6000_0010 with data 0xDEADBEEF, BE=4'hF, Id=5 -> one response beat, Cntl=8'h01, Id=5, exactly 3 cycles after accept (RESP_DELAY=2); a following single read of 0x6000_0010 returns 0xDEADBEEF.
2. Partial write of 0x11223344 with BE=4'b0101 over an existing 0xDEADBEEF, then read -> 0xDE22BE44.
3. Block write of 4 beats (size=1) to 0x6000_0020 with data 1,2,3,4, then block read of 4 beats from 0x6000_0028 -> response beats 1,2,3,4 (block-aligned), Cntl[0]=1 only on beat 4; PORespRdy held low 5 cycles on beat 2 -> data held stable, no beat dropped.
4. Single read of 0x5FFF_FFFC and write to 0x6000_1000 -> each returns one beat with Cntl=8'h11 and data 0; memory unchanged; bad opcode 4'h3 -> same error response.
5. Reset asserted during RESP of a 16-beat block read after beat 6 -> PIRespValid=0 the next cycle, PIReqRdy=1 one cycle after Reset drops, and a new single read completes normally.
6. RESP_DELAY=0 build: single read -> PIRespValid=1 the cycle after the request is accepted; back-to-back requests are accepted no sooner than 1 cycle after the prior response completes.
